// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequenced ALU datapath.
// Comb-free: constants and types only, no latency or flow-control of its own.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_NOT = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_SIGN  = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_R0 = 3'd1,
      ST_RD_RX = 3'd2,
      ST_LOAD  = 3'd3,
      ST_WB    = 3'd4
   } state_t;

endpackage

// File: rtl/alu_seq.sv
// Sequencer: reads R0 and RX from an external regfile, feeds an external ALU, writes RD back.
// Fixed 5-cycle cadence (DONE in the 4th cycle after accept); START is ignored while busy.
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RF_AW  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [RF_AW-1:0]  rx_sel,
   input  logic [RF_AW-1:0]  rd_sel,
   output logic              busy,
   output logic              done,
   output logic [RF_AW-1:0]  rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [DATA_W-1:0] alu_r0,
   output logic [DATA_W-1:0] alu_rx,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [2:0]        alu_flags,
   output logic [2:0]        flags
);

   state_t           state;
   logic [2:0]       op_q;
   logic [RF_AW-1:0] rx_q;
   logic [RF_AW-1:0] rd_q;

   // The ALU is combinational on the registered operands, so WB data is its live result.
   assign rf_wdata = alu_res;

   // Outputs are registered on the transition into the state that owns them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         op_q     <= '0;
         rx_q     <= '0;
         rd_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rf_raddr <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         alu_r0   <= '0;
         alu_rx   <= '0;
         alu_op   <= '0;
         flags    <= '0;
      end else begin
         done  <= 1'b0;
         rf_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  rx_q     <= rx_sel;
                  rd_q     <= rd_sel;
                  busy     <= 1'b1;
                  rf_raddr <= '0;
                  state    <= ST_RD_R0;
               end
            end
            ST_RD_R0: begin
               rf_raddr <= rx_q;
               state    <= ST_RD_RX;
            end
            ST_RD_RX: begin
               alu_r0   <= rf_rdata;
               rf_raddr <= '0;
               state    <= ST_LOAD;
            end
            ST_LOAD: begin
               alu_rx   <= rf_rdata;
               alu_op   <= op_q;
               rf_we    <= 1'b1;
               rf_waddr <= rd_q;
               done     <= 1'b1;
               state    <= ST_WB;
            end
            ST_WB: begin
               flags    <= alu_flags;
               busy     <= 1'b0;
               rf_waddr <= '0;
               state    <= ST_IDLE;
            end
            default: begin
               busy     <= 1'b0;
               rf_raddr <= '0;
               rf_waddr <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural regfile and ALU around the DUT, directed ops, write-back scoreboard.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int DATA_W = 8;
   localparam int RF_AW  = 3;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [2:0]        op;
   logic [RF_AW-1:0]  rx_sel;
   logic [RF_AW-1:0]  rd_sel;
   logic              busy;
   logic              done;
   logic [RF_AW-1:0]  rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic              rf_we;
   logic [RF_AW-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] alu_r0;
   logic [DATA_W-1:0] alu_rx;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_res;
   logic [2:0]        alu_flags;
   logic [2:0]        flags;

   typedef struct packed {
      logic [2:0] waddr;
      logic [7:0] wdata;
      logic [2:0] flags;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_seq #(.DATA_W(DATA_W), .RF_AW(RF_AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rx_sel(rx_sel), .rd_sel(rd_sel),
      .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_r0(alu_r0), .alu_rx(alu_rx),
      .alu_op(alu_op), .alu_res(alu_res), .alu_flags(alu_flags), .flags(flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read regfile; the bench preloads it through a side write port.
   logic [7:0] rf [8];
   logic       tb_we;
   logic [2:0] tb_waddr;
   logic [7:0] tb_wdata;

   always @(posedge clk) begin
      rf_rdata <= rf[rf_raddr];
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      else if (tb_we) rf[tb_waddr] <= tb_wdata;
   end

   logic [8:0] alu_wide;
   logic [7:0] alu_r;
   logic       alu_c;
   always_comb begin
      alu_wide  = '0;
      alu_r     = '0;
      alu_c     = 1'b0;
      alu_flags = '0;
      case (alu_op)
         OP_ADD: begin alu_wide = {1'b0, alu_r0} + {1'b0, alu_rx}; alu_r = alu_wide[7:0]; alu_c = alu_wide[8]; end
         OP_SUB: begin alu_wide = {1'b0, alu_r0} - {1'b0, alu_rx}; alu_r = alu_wide[7:0]; alu_c = alu_wide[8]; end
         OP_SHL: begin alu_r = alu_r0 << 1; alu_c = alu_r0[7]; end
         OP_SHR: begin alu_r = alu_r0 >> 1; alu_c = alu_r0[0]; end
         OP_NOT: alu_r = ~alu_rx;
         OP_AND: alu_r = alu_r0 & alu_rx;
         OP_OR:  alu_r = alu_r0 | alu_rx;
         default: alu_r = alu_r0 ^ alu_rx;
      endcase
      alu_res              = alu_r;
      alu_flags[FLAG_ZERO]  = (alu_r == 8'h00);
      alu_flags[FLAG_CARRY] = alu_c;
      alu_flags[FLAG_SIGN]  = alu_r[7];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rf_load(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we    = 1'b1;
      tb_waddr = a;
      tb_wdata = d;
      @(negedge clk);
      tb_we    = 1'b0;
   endtask

   // Issues one op, queues its expected write, and measures accept-to-DONE latency in edges.
   task automatic run_op(input string name, input logic [2:0] o, input logic [2:0] rx,
                         input logic [2:0] rd, input logic [7:0] ed, input logic [2:0] ef);
      int lat;
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rx_sel = rx;
      rd_sel = rd;
      sb_q.push_back(exp_t'{rd, ed, ef});
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({name, "_latency"}, lat, 4);
      @(negedge clk);
   endtask

   // Monitor: every regfile write must match the head of the scoreboard; flags land one cycle later.
   initial begin
      exp_t       e;
      logic [2:0] ef;
      bit         fchk;
      fchk = 1'b0;
      ef   = '0;
      forever begin
         @(negedge clk);
         if (fchk) begin
            chk("flags", 32'(flags), 32'(ef));
            fchk = 1'b0;
         end
         if (rf_we === 1'b1) begin
            chk("write_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("waddr", 32'(rf_waddr), 32'(e.waddr));
               chk("wdata", 32'(rf_wdata), 32'(e.wdata));
               chk("done_with_we", 32'(done), 1);
               ef   = e.flags;
               fchk = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int we_k [3];
      int we_n;
      int idle_n;

      rst_n = 1'b0; start = 1'b1; op = OP_ADD; rx_sel = 3'd1; rd_sel = 3'd1;
      tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
      for (int i = 0; i < 8; i++) rf_load(3'(i), 8'h00);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_done",   32'(done), 0);
      chk("rst_we",     32'(rf_we), 0);
      chk("rst_raddr",  32'(rf_raddr), 0);
      chk("rst_alu_r0", 32'(alu_r0), 0);
      chk("rst_alu_rx", 32'(alu_rx), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_flags",  32'(flags), 0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("start_during_reset_ignored", 32'(busy), 0);

      rf_load(3'd0, 8'h05); rf_load(3'd3, 8'h03);
      run_op("add", OP_ADD, 3'd3, 3'd2, 8'h08, 3'b000);
      chk("add_r2", 32'(rf[2]), 32'h08);

      rf_load(3'd0, 8'h03); rf_load(3'd1, 8'h05);
      run_op("sub", OP_SUB, 3'd1, 3'd4, 8'hFE, 3'b011);
      chk("sub_r4", 32'(rf[4]), 32'hFE);

      rf_load(3'd0, 8'hAA); rf_load(3'd5, 8'hAA);
      run_op("xor", OP_XOR, 3'd5, 3'd6, 8'h00, 3'b100);
      chk("xor_r6", 32'(rf[6]), 32'h00);

      rf_load(3'd0, 8'h10);
      run_op("r0_dbl1", OP_ADD, 3'd0, 3'd0, 8'h20, 3'b000);
      chk("r0_after_1", 32'(rf[0]), 32'h20);
      run_op("r0_dbl2", OP_ADD, 3'd0, 3'd0, 8'h40, 3'b000);
      chk("r0_after_2", 32'(rf[0]), 32'h40);

      rf_load(3'd7, 8'h0F);
      run_op("not", OP_NOT, 3'd7, 3'd1, 8'hF0, 3'b001);

      // Abort in LOAD: no write may follow and flags must clear.
      rf_load(3'd0, 8'h11); rf_load(3'd2, 8'h22); rf_load(3'd5, 8'h55);
      @(negedge clk);
      start = 1'b1; op = OP_ADD; rx_sel = 3'd2; rd_sel = 3'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("busy_in_load", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_we",    32'(rf_we), 0);
      chk("abort_busy",  32'(busy), 0);
      chk("abort_done",  32'(done), 0);
      chk("abort_flags", 32'(flags), 0);
      chk("abort_r0",    32'(alu_r0), 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_r5_kept", 32'(rf[5]), 32'h55);
      chk("abort_r2_kept", 32'(rf[2]), 32'h22);

      // START held high for 15 edges: three ops, writes 5 cycles apart.
      rf_load(3'd0, 8'h01); rf_load(3'd1, 8'h02);
      for (int i = 0; i < 3; i++) sb_q.push_back(exp_t'{3'd3, 8'h03, 3'b000});
      we_n = 0; idle_n = 0;
      for (int i = 0; i < 3; i++) we_k[i] = -100;
      @(negedge clk);
      start = 1'b1; op = OP_OR; rx_sel = 3'd1; rd_sel = 3'd3;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (rf_we) begin
            if (we_n < 3) we_k[we_n] = k;
            we_n++;
         end
         if (k < 15 && !busy) idle_n++;
         if (k == 14) start = 1'b0;
      end
      chk("held_we_count", we_n, 3);
      chk("held_first_we", we_k[0], 3);
      chk("held_spacing_1", we_k[1] - we_k[0], 5);
      chk("held_spacing_2", we_k[2] - we_k[1], 5);
      chk("held_idle_cycles", idle_n, 3);
      chk("held_r3", 32'(rf[3]), 32'h03);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
